// File: rtl/rr_arb_pkg.sv
// Shared request-vector type and encodings for the round-robin arbiter request queues.
package rr_arb_pkg;

  typedef logic [1:0] req_vec_t;

  localparam req_vec_t REQ_NONE = 2'b00;
  localparam req_vec_t REQ_0    = 2'b01;
  localparam req_vec_t REQ_1    = 2'b10;
  localparam req_vec_t REQ_BOTH = 2'b11;

endpackage

// File: rtl/rr_arb_fifo.sv
// Single-clock FIFO with occupancy count and combinational head read; push is refused when
// full and pop is ignored when empty.
module rr_arb_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic [DATA_W-1:0]         head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  a_count_range: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/rr_arb_request_queues.sv
// Two per-client FIFOs feeding a 2-way round-robin arbiter, merged into one tagged output stream.
// Define RRQ_ERR_EN to add the sticky err flag for illegal grants.
module rr_arb_request_queues
  import rr_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  output logic [1:0]        requests,
  input  logic [1:0]        grants,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
`ifdef RRQ_ERR_EN
  output logic              err,
`endif
  output logic              out_src
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              full0, full1, empty0, empty1;
  logic [CNT_W-1:0]  count0, count1;
  logic [DATA_W-1:0] head0, head1;
  logic              push0, push1;
  req_vec_t          pop;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_src_q;

  assign in0_ready = ~full0;
  assign in1_ready = ~full1;
  assign push0     = in0_valid & in0_ready;
  assign push1     = in1_valid & in1_ready;

  rr_arb_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo0 (
    .clk     (clk),
    .rst     (rst),
    .push    (push0),
    .wr_data (in0_data),
    .pop     (pop[0]),
    .full    (full0),
    .empty   (empty0),
    .count   (count0),
    .head    (head0)
  );

  rr_arb_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .push    (push1),
    .wr_data (in1_data),
    .pop     (pop[1]),
    .full    (full1),
    .empty   (empty1),
    .count   (count1),
    .head    (head1)
  );

  // Grants arrive one cycle after the request; an entry already granted is not requested
  // again, so a single-entry queue is never granted twice.
  assign requests[0] = (count0 - CNT_W'(grants[0])) != '0;
  assign requests[1] = (count1 - CNT_W'(grants[1])) != '0;

  // Queue 0 wins an illegal double grant; grants to empty queues are dropped.
  always_comb begin
    pop = REQ_NONE;
    if (grants[0] && !empty0) begin
      pop = REQ_0;
    end else if (grants[1] && !grants[0] && !empty1) begin
      pop = REQ_1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      out_valid_q <= (pop != REQ_NONE);
      if (pop == REQ_0) begin
        out_data_q <= head0;
        out_src_q  <= 1'b0;
      end else if (pop == REQ_1) begin
        out_data_q <= head1;
        out_src_q  <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef RRQ_ERR_EN
  logic err_q;
  logic bad_grant;

  assign bad_grant = (grants == REQ_BOTH) | (grants[0] & empty0) | (grants[1] & empty1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | bad_grant;
    end
  end

  assign err = err_q;
`endif

  a_pop_onehot: assert property (@(posedge clk) disable iff (rst) pop != REQ_BOTH);

endmodule
